// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: LC-3b word, FSM states and port identifiers.
package cpu_mem_arbiter_pkg;

    localparam int LC3B_W = 16;

    typedef logic [LC3B_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } mem_port_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of CPU-side port signals and the physical memory port around the arbiter.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0] mem_addr1;
    logic              mem_read1;
    logic [DATA_W-1:0] mem_rdata1;
    logic              mem_resp1;

    logic [ADDR_W-1:0] mem_addr2;
    logic              mem_read2;
    logic              mem_write2;
    logic [DATA_W-1:0] mem_wdata2;
    logic [DATA_W-1:0] mem_rdata2;
    logic              mem_resp2;

    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter view.
    modport slave (
        input  mem_addr1, mem_read1,
        output mem_rdata1, mem_resp1,
        input  mem_addr2, mem_read2, mem_write2, mem_wdata2,
        output mem_rdata2, mem_resp2,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment view: the CPU datapath plus the physical memory.
    modport master (
        output mem_addr1, mem_read1,
        input  mem_rdata1, mem_resp1,
        output mem_addr2, mem_read2, mem_write2, mem_wdata2,
        input  mem_rdata2, mem_resp2,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cpu_mem_arbiter_picker.sv
// Combinational 2-way picker: fixed data-port priority or round-robin against the last served port.
module mem_arb_picker
    import cpu_mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic      req1_i,
    input  logic      req2_i,
    input  mem_port_t last_served_i,
    output mem_port_t grant_o
);

    always_comb begin
        grant_o = PORT_I;
        if (req1_i && req2_i) begin
            if (DATA_FIRST) begin
                grant_o = PORT_D;
            end else begin
                grant_o = (last_served_i == PORT_D) ? PORT_I : PORT_D;
            end
        end else if (req2_i) begin
            grant_o = PORT_D;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises the instruction-fetch and data ports onto one physical memory port.
//   state | meaning
//   IDLE  | sample requests, grant one and latch it
//   BUSY  | pmem strobe held from the request register until pmem_resp
//   RESP  | one-cycle resp pulse to the granted port
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter bit DATA_FIRST = 1'b1
) (
    input logic               clk,
    input logic               reset,
    cpu_mem_arbiter_if.slave  bus
);

    mem_arb_state_t    state_q;
    mem_port_t         port_q;
    mem_port_t         last_served_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic              resp1_q;
    logic              resp2_q;

    logic              req1;
    logic              req2;
    mem_port_t         grant;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              write_d;

    // read2 together with write2 counts as a single write request.
    assign req1 = bus.mem_read1;
    assign req2 = bus.mem_read2 | bus.mem_write2;

    mem_arb_picker #(
        .DATA_FIRST(DATA_FIRST)
    ) u_picker (
        .req1_i        (req1),
        .req2_i        (req2),
        .last_served_i (last_served_q),
        .grant_o       (grant)
    );

    always_comb begin
        addr_d  = bus.mem_addr1;
        wdata_d = '0;
        write_d = 1'b0;
        if (grant == PORT_D) begin
            addr_d  = bus.mem_addr2;
            wdata_d = bus.mem_wdata2;
            write_d = bus.mem_write2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            port_q        <= PORT_I;
            last_served_q <= PORT_I;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            resp1_q       <= 1'b0;
            resp2_q       <= 1'b0;
        end else begin
            resp1_q <= 1'b0;
            resp2_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req1 || req2) begin
                        port_q        <= grant;
                        last_served_q <= grant;
                        addr_q        <= addr_d;
                        wdata_q       <= wdata_d;
                        write_q       <= write_d;
                        pmem_read_q   <= ~write_d;
                        pmem_write_q  <= write_d;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.pmem_resp) begin
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        // Writes leave the port's read data untouched.
                        if (!write_q && port_q == PORT_I) rdata1_q <= bus.pmem_rdata;
                        if (!write_q && port_q == PORT_D) rdata2_q <= bus.pmem_rdata;
                        resp1_q <= (port_q == PORT_I);
                        resp2_q <= (port_q == PORT_D);
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.mem_rdata1   = rdata1_q;
    assign bus.mem_rdata2   = rdata2_q;
    assign bus.mem_resp1    = resp1_q;
    assign bus.mem_resp2    = resp2_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: transaction model on a data-first instance, plus a round-robin instance.
module tb_cpu_mem_arbiter;

    localparam bit DF_A = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
    cpu_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

    cpu_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DATA_FIRST(DF_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    cpu_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DATA_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model of dut_a: one outstanding access, a one-cycle answer,
    // then one quiet cycle before requests are sampled again.
    bit          m_busy;
    int          m_port;
    int          m_resp;
    int          m_last;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rd1;
    logic [15:0] m_rd2;

    function automatic int pick(input bit r1, input bit r2, input int last);
        if (r1 && r2) return DF_A ? 2 : ((last == 1) ? 2 : 1);
        return r1 ? 1 : 2;
    endfunction

    wire a_r1 = ifa.mem_read1;
    wire a_r2 = ifa.mem_read2 | ifa.mem_write2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_port <= 0; m_resp <= 0; m_last <= 1; m_wr <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_rd1 <= '0; m_rd2 <= '0;
        end else if (m_resp != 0) begin
            m_resp <= 0;
        end else if (m_busy) begin
            if (ifa.pmem_resp) begin
                m_busy <= 1'b0;
                m_resp <= m_port;
                if (!m_wr && m_port == 1) m_rd1 <= ifa.pmem_rdata;
                if (!m_wr && m_port == 2) m_rd2 <= ifa.pmem_rdata;
            end
        end else if (a_r1 || a_r2) begin
            m_busy <= 1'b1;
            m_port <= pick(a_r1, a_r2, m_last);
            m_last <= pick(a_r1, a_r2, m_last);
            if (pick(a_r1, a_r2, m_last) == 1) begin
                m_wr <= 1'b0; m_addr <= ifa.mem_addr1;
            end else begin
                m_wr <= ifa.mem_write2; m_addr <= ifa.mem_addr2; m_wdata <= ifa.mem_wdata2;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_pmem_read",  32'(ifa.pmem_read),  32'(m_busy && !m_wr));
        chk("m_pmem_write", 32'(ifa.pmem_write), 32'(m_busy && m_wr));
        chk("m_resp1",      32'(ifa.mem_resp1),  32'(m_resp == 1));
        chk("m_resp2",      32'(ifa.mem_resp2),  32'(m_resp == 2));
        chk("m_rdata1",     32'(ifa.mem_rdata1), 32'(m_rd1));
        chk("m_rdata2",     32'(ifa.mem_rdata2), 32'(m_rd2));
        if (m_busy) chk("m_pmem_address", 32'(ifa.pmem_address), 32'(m_addr));
        if (m_busy && m_wr) chk("m_pmem_wdata", 32'(ifa.pmem_wdata), 32'(m_wdata));
    end

    // Directed access on dut_a, called just after a falling edge.
    task automatic access(input string name, input int port, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [15:0] wdata, input int nbusy,
                          input logic [15:0] rdat, output int strobes, output int resps,
                          output int lat, output logic [15:0] cap_addr,
                          output logic [15:0] cap_wdata, output bit cap_wr, output bit cap_rd);
        int cyc;
        bit done;
        bit rsp;
        strobes = 0; resps = 0; lat = 0; cyc = 1; done = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_wr = 1'b0; cap_rd = 1'b0;
        if (port == 1) begin
            ifa.mem_read1 = 1'b1; ifa.mem_addr1 = addr;
        end else begin
            ifa.mem_read2 = rd; ifa.mem_write2 = wr; ifa.mem_addr2 = addr; ifa.mem_wdata2 = wdata;
        end
        ifa.pmem_resp = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cyc++;
            rsp = (port == 1) ? ifa.mem_resp1 : ifa.mem_resp2;
            if (rsp) begin
                resps++; lat = cyc; done = 1'b1;
                ifa.mem_read1 = 1'b0; ifa.mem_read2 = 1'b0; ifa.mem_write2 = 1'b0;
            end
            if (ifa.pmem_read || ifa.pmem_write) begin
                strobes++;
                if (strobes == 1) begin
                    cap_addr = ifa.pmem_address; cap_wdata = ifa.pmem_wdata;
                    cap_wr = ifa.pmem_write; cap_rd = ifa.pmem_read;
                end
                if (strobes == nbusy) begin
                    ifa.pmem_resp = 1'b1; ifa.pmem_rdata = rdat;
                end
            end else begin
                ifa.pmem_resp = 1'b0;
            end
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        ifa.mem_read1 = 1'b0; ifa.mem_read2 = 1'b0; ifa.mem_write2 = 1'b0;
        @(negedge clk);
        ifa.pmem_resp = 1'b0;
        rsp = (port == 1) ? ifa.mem_resp1 : ifa.mem_resp2;
        if (rsp) resps++;
        if (ifa.pmem_read || ifa.pmem_write) strobes++;
    endtask

    task automatic wait_strobe(input string name, output int n);
        n = 0;
        while (!(ifa.pmem_read || ifa.pmem_write) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_strobe_seen"}, 32'(ifa.pmem_read | ifa.pmem_write), 32'd1);
    endtask

    initial begin
        int st, rs, lat, n, k, got;
        logic [15:0] ca, cw;
        bit cwr, crd;
        int op;

        ifa.mem_addr1 = '0; ifa.mem_read1 = 1'b0; ifa.mem_addr2 = '0; ifa.mem_read2 = 1'b0;
        ifa.mem_write2 = 1'b0; ifa.mem_wdata2 = '0; ifa.pmem_rdata = '0; ifa.pmem_resp = 1'b0;
        ifb.mem_addr1 = '0; ifb.mem_read1 = 1'b0; ifb.mem_addr2 = '0; ifb.mem_read2 = 1'b0;
        ifb.mem_write2 = 1'b0; ifb.mem_wdata2 = '0; ifb.pmem_rdata = '0; ifb.pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pmem_read", 32'(ifa.pmem_read), 32'd0);
        chk("rst_resp1", 32'(ifa.mem_resp1), 32'd0);
        chk("rst_rdata2", 32'(ifa.mem_rdata2), 32'd0);

        // Read1 with two BUSY cycles.
        access("t1", 1, 1'b1, 1'b0, 16'h3000, 16'h0, 2, 16'hBEEF, st, rs, lat, ca, cw, cwr, crd);
        chk("t1_strobes", 32'(st), 32'd2);
        chk("t1_resps", 32'(rs), 32'd1);
        chk("t1_rdata1", 32'(ifa.mem_rdata1), 32'h0000BEEF);
        chk("t1_addr", 32'(ca), 32'h00003000);
        chk("t1_lat", 32'(lat), 32'd4);

        // Write2 leaves read data of port 2 alone.
        access("t2r", 2, 1'b1, 1'b0, 16'h4000, 16'h0, 1, 16'hA5A5, st, rs, lat, ca, cw, cwr, crd);
        chk("t2_pre_rdata2", 32'(ifa.mem_rdata2), 32'h0000A5A5);
        access("t2", 2, 1'b0, 1'b1, 16'h4002, 16'h1234, 1, 16'hDEAD, st, rs, lat, ca, cw, cwr, crd);
        chk("t2_addr", 32'(ca), 32'h00004002);
        chk("t2_wdata", 32'(cw), 32'h00001234);
        chk("t2_write", 32'(cwr), 32'd1);
        chk("t2_resps", 32'(rs), 32'd1);
        chk("t2_rdata2", 32'(ifa.mem_rdata2), 32'h0000A5A5);

        // Tie with data-first: port 2, quiet cycle, then port 1.
        ifa.mem_read1 = 1'b1; ifa.mem_addr1 = 16'h5000;
        ifa.mem_read2 = 1'b1; ifa.mem_addr2 = 16'h6000;
        wait_strobe("t3a", n);
        chk("t3_first_addr", 32'(ifa.pmem_address), 32'h00006000);
        ifa.pmem_resp = 1'b1; ifa.pmem_rdata = 16'h6666;
        @(negedge clk);
        ifa.pmem_resp = 1'b0;
        chk("t3_resp2", 32'(ifa.mem_resp2), 32'd1);
        ifa.mem_read2 = 1'b0;
        wait_strobe("t3b", n);
        chk("t3_gap", 32'(n), 32'd2);
        chk("t3_second_addr", 32'(ifa.pmem_address), 32'h00005000);
        ifa.pmem_resp = 1'b1; ifa.pmem_rdata = 16'h5555;
        @(negedge clk);
        ifa.pmem_resp = 1'b0;
        chk("t3_resp1", 32'(ifa.mem_resp1), 32'd1);
        chk("t3_rdata1", 32'(ifa.mem_rdata1), 32'h00005555);
        ifa.mem_read1 = 1'b0;
        @(negedge clk);

        // Reset in BUSY drops the strobe at once; stray pmem_resp afterwards is ignored.
        ifa.mem_read1 = 1'b1; ifa.mem_addr1 = 16'h7000;
        wait_strobe("t4", n);
        #2 reset = 1'b1;
        #1 chk("t4_read_drop", 32'(ifa.pmem_read), 32'd0);
        @(negedge clk);
        ifa.mem_read1 = 1'b0;
        reset = 1'b0;
        ifa.pmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_resp", 32'(ifa.mem_resp1 | ifa.mem_resp2), 32'd0);
        end
        ifa.pmem_resp = 1'b0;
        @(negedge clk);

        // read2 and write2 together: one write, one resp.
        access("t5", 2, 1'b1, 1'b1, 16'h4100, 16'hCAFE, 1, 16'h0BAD, st, rs, lat, ca, cw, cwr, crd);
        chk("t5_strobes", 32'(st), 32'd1);
        chk("t5_resps", 32'(rs), 32'd1);
        chk("t5_is_write", 32'({cwr, crd}), 32'b10);
        chk("t5_wdata", 32'(cw), 32'h0000CAFE);
        chk("t5_rdata2", 32'(ifa.mem_rdata2), 32'h00000000);

        // Minimum latency and back-to-back port-1 reads.
        access("t6a", 1, 1'b1, 1'b0, 16'h3000, 16'h0, 1, 16'h1111, st, rs, lat, ca, cw, cwr, crd);
        chk("t6_lat", 32'(lat), 32'd3);
        chk("t6a_rdata1", 32'(ifa.mem_rdata1), 32'h00001111);
        access("t6b", 1, 1'b1, 1'b0, 16'h3002, 16'h0, 1, 16'h2222, st, rs, lat, ca, cw, cwr, crd);
        chk("t6b_resps", 32'(rs), 32'd1);
        chk("t6b_addr", 32'(ca), 32'h00003002);
        chk("t6b_rdata1", 32'(ifa.mem_rdata1), 32'h00002222);

        // Random traffic; the negedge compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            if (!ifa.mem_read1) begin
                if ($urandom_range(0, 3) == 0) begin
                    ifa.mem_read1 = 1'b1; ifa.mem_addr1 = 16'($urandom);
                end
            end else if (ifa.mem_resp1) begin
                ifa.mem_read1 = 1'($urandom_range(0, 1)); ifa.mem_addr1 = 16'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                ifa.mem_read1 = 1'b0;
            end
            if (!(ifa.mem_read2 || ifa.mem_write2)) begin
                if ($urandom_range(0, 3) == 0) begin
                    op = int'($urandom_range(0, 2));
                    ifa.mem_read2 = (op != 1); ifa.mem_write2 = (op != 0);
                    ifa.mem_addr2 = 16'($urandom); ifa.mem_wdata2 = 16'($urandom);
                end
            end else if (ifa.mem_resp2 || $urandom_range(0, 31) == 0) begin
                ifa.mem_read2 = 1'b0; ifa.mem_write2 = 1'b0;
            end
            ifa.pmem_resp = ($urandom_range(0, 2) == 0);
            ifa.pmem_rdata = 16'($urandom);
        end
        ifa.mem_read1 = 1'b0; ifa.mem_read2 = 1'b0; ifa.mem_write2 = 1'b0; ifa.pmem_resp = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin instance: permanent tie, service must alternate starting with port 2.
        ifb.mem_addr1 = 16'h1000; ifb.mem_addr2 = 16'h2000;
        ifb.mem_read1 = 1'b1; ifb.mem_read2 = 1'b1;
        k = 0;
        for (int cy = 0; cy < 100 && k < 8; cy++) begin
            @(negedge clk);
            ifb.pmem_resp = ifb.pmem_read | ifb.pmem_write;
            ifb.pmem_rdata = ifb.pmem_address + 16'h0001;
            if (ifb.mem_resp1 || ifb.mem_resp2) begin
                got = ifb.mem_resp2 ? 2 : 1;
                chk("rr_order", 32'(got), (k % 2 == 0) ? 32'd2 : 32'd1);
                if (got == 2) chk("rr_rdata2", 32'(ifb.mem_rdata2), 32'h00002001);
                else          chk("rr_rdata1", 32'(ifb.mem_rdata1), 32'h00001001);
                k++;
            end
        end
        chk("rr_count", 32'(k), 32'd8);
        ifb.mem_read1 = 1'b0; ifb.mem_read2 = 1'b0; ifb.pmem_resp = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
